spi_px_master: RTL and testbench

//  SPI initiator (mode 0, MSB first, full duplex) that drives the pixel SPI

---
 rtl/spi_px_master_if.sv | 31 +++
 rtl/spi_px_master.sv | 173 +++++++++++++++++
 tb/tb_spi_px_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_px_master_if.sv
// Pixel-side handshake and SPI pin bundle for spi_px_master.
// Signals keep their pin-level names. The master modport is the view from
// inside the SPI initiator. The slave modport is the view from the pixel
// source and the SPI responder.
interface spi_px_master_if #(
    parameter int PX_BITS = 24
);
    logic [PX_BITS-1:0] tx_px_i;
    logic               tx_valid_i;
    logic               tx_ready_o;
    logic [PX_BITS-1:0] rx_px_o;
    logic               rx_valid_o;
    logic               busy_o;
    logic               spi_sck_o;
    logic               spi_cs_o;
    logic               spi_sdo_o;
    logic               spi_sdi_i;
    logic [2:0]         dbg_state_o;

    modport master (
        input  tx_px_i, tx_valid_i, spi_sdi_i,
        output tx_ready_o, rx_px_o, rx_valid_o, busy_o,
               spi_sck_o, spi_cs_o, spi_sdo_o, dbg_state_o
    );

    modport slave (
        output tx_px_i, tx_valid_i, spi_sdi_i,
        input  tx_ready_o, rx_px_o, rx_valid_o, busy_o,
               spi_sck_o, spi_cs_o, spi_sdo_o, dbg_state_o
    );
endinterface

// File: rtl/spi_px_master.sv
// SPI initiator for the pixel responder: mode 0, MSB first, full duplex.
// Each frame sends one pixel on MOSI and captures one pixel from MISO.
//
// Handshake: a pixel is accepted on a rising edge where tx_valid_i and
// tx_ready_o are both high. tx_ready_o is high only in IDLE. The source
// must hold tx_px_i stable until it is accepted. rx_valid_o is a one-cycle
// pulse with no back-pressure. rx_px_o keeps its value until the next
// frame completes.
//
// SCK and CS are decoded from registered state, so a reset takes them to
// idle immediately.
module spi_px_master #(
    parameter int PX_BITS  = 24,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    spi_px_master_if.master   bus
);

    // A single phase counter serves SETUP, SHIFT (one full SCK period), HOLD and GAP.
    localparam int CNT_MAX0 = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
    localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W    = $clog2(PX_BITS + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SCK_HIGH   = CNT_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BITS_FULL  = BIT_W'(PX_BITS);
    localparam logic [BIT_W-1:0] BITS_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [PX_BITS-1:0] tx_sh_q;
    logic [PX_BITS-1:0] rx_sh_q;
    logic [PX_BITS-1:0] rx_px_q;
    logic               rx_valid_q;
    logic               out_of_reset_q;

    logic               tx_ready;
    logic               load;
    logic               shift;
    logic               finish;
    logic               cs_active;

    // tx_ready is held low during reset and rises on the first cycle after release.
    assign tx_ready = out_of_reset_q && (state_q == S_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle strobes for the datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_ready && bus.tx_valid_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Last cycle of the high phase: sample MISO, then SCK falls.
                if (cnt_q == BIT_LAST) begin
                    shift = 1'b1;
                    cnt_d = '0;
                    if (bit_cnt_q == BITS_ONE) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    finish  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: phase counter, shift registers and the received-pixel register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            tx_sh_q        <= '0;
            rx_sh_q        <= '0;
            rx_px_q        <= '0;
            rx_valid_q     <= 1'b0;
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
            cnt_q          <= cnt_d;
            rx_valid_q     <= finish;
            if (load) begin
                tx_sh_q   <= bus.tx_px_i;
                rx_sh_q   <= '0;
                bit_cnt_q <= BITS_FULL;
            end else if (shift) begin
                tx_sh_q   <= {tx_sh_q[PX_BITS-2:0], 1'b0};
                rx_sh_q   <= {rx_sh_q[PX_BITS-2:0], bus.spi_sdi_i};
                bit_cnt_q <= bit_cnt_q - 1'b1;
            end
            if (finish) begin
                rx_px_q <= rx_sh_q;
            end
        end
    end

    // CS is low across SETUP, SHIFT and HOLD.
    always_comb begin
        cs_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    end

    assign bus.tx_ready_o  = tx_ready;
    assign bus.rx_px_o     = rx_px_q;
    assign bus.rx_valid_o  = rx_valid_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.spi_cs_o    = ~cs_active;
    assign bus.spi_sck_o   = (state_q == S_SHIFT) && (cnt_q >= SCK_HIGH);
    assign bus.spi_sdo_o   = cs_active & tx_sh_q[PX_BITS-1];
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_px_master.sv
// Bench for spi_px_master: table of frames, a MISO responder model, a pin
// monitor, and a scoreboard of expected rx pixels and MOSI words.
module tb_spi_px_master;

    localparam int PX       = 24;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int FRAME_LEN = CS_SETUP + 2 * CLK_DIV * PX + CS_HOLD;
    localparam int LIMIT     = 2000;

    logic clk_i;
    logic nreset_i;
    logic loopback;

    spi_px_master_if #(.PX_BITS(PX)) bus ();

    spi_px_master #(
        .PX_BITS (PX),
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    logic [PX-1:0] exp_q[$];
    logic [PX-1:0] mosi_q[$];
    logic [PX-1:0] miso_q[$];
    int            gap_log[$];
    int n_vec = 0;
    int n_err = 0;

    // monitor state
    logic          prev_cs   = 1'b1;
    logic          prev_sck  = 1'b0;
    logic          prev_sdo  = 1'b0;
    logic          prev_rxv  = 1'b0;
    logic          in_frame  = 1'b0;
    logic          have_gap  = 1'b0;
    int            cs_low_cnt = 0;
    int            gap_cnt    = 0;
    int            mon_rise   = 0;
    int            mon_frames = 0;
    int            unstable   = 0;
    int            stray_edges = 0;
    logic [PX-1:0] mosi_word = '0;
    logic [PX-1:0] miso_sh   = '0;

    // MISO responder: loopback or a preloaded word shifted out MSB first.
    assign bus.spi_sdi_i = loopback ? bus.spi_sdo_o : miso_sh[PX-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor + responder ----------------
    always @(negedge clk_i) begin
        if (!nreset_i) begin
            prev_cs    = 1'b1;
            prev_sck   = 1'b0;
            prev_sdo   = 1'b0;
            prev_rxv   = 1'b0;
            in_frame   = 1'b0;
            have_gap   = 1'b0;
            mon_rise   = 0;
            cs_low_cnt = 0;
            gap_cnt    = 0;
        end else begin
            if (bus.spi_cs_o && bus.spi_sck_o !== 1'b0) stray_edges++;
            if (prev_cs && !bus.spi_cs_o) begin
                if (have_gap) gap_log.push_back(gap_cnt);
                in_frame   = 1'b1;
                mon_frames++;
                mon_rise   = 0;
                cs_low_cnt = 1;
                unstable   = 0;
                mosi_word  = '0;
                miso_sh    = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
            end else if (!bus.spi_cs_o) begin
                cs_low_cnt++;
                if (bus.spi_sck_o && !prev_sck) begin
                    mon_rise++;
                    mosi_word = {mosi_word[PX-2:0], bus.spi_sdo_o};
                    if (bus.spi_sdo_o !== prev_sdo) unstable++;
                end
                if (!bus.spi_sck_o && prev_sck) miso_sh = {miso_sh[PX-2:0], 1'b0};
            end else if (!prev_cs && bus.spi_cs_o) begin
                if (in_frame) begin
                    check("cs_low_len", cs_low_cnt, FRAME_LEN);
                    check("sck_rises", mon_rise, PX);
                    check("mosi_stable", unstable, 0);
                    if (mosi_q.size() > 0) check("mosi_word", mosi_word, mosi_q.pop_front());
                    else check("mosi_q_empty", 1, 0);
                end
                in_frame = 1'b0;
                have_gap = 1'b1;
                gap_cnt  = 1;
            end else begin
                gap_cnt++;
            end
            if (bus.rx_valid_o) begin
                check("rx_valid_single", prev_rxv, 0);
                if (exp_q.size() > 0) check("rx_px", bus.rx_px_o, exp_q.pop_front());
                else check("rx_valid_unexpected", 1, 0);
            end
            prev_cs  = bus.spi_cs_o;
            prev_sck = bus.spi_sck_o;
            prev_sdo = bus.spi_sdo_o;
            prev_rxv = bus.rx_valid_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [PX-1:0] px, input logic [PX-1:0] miso, input logic [PX-1:0] rx_exp);
        int t = 0;
        bus.tx_px_i    = px;
        bus.tx_valid_i = 1'b1;
        while (!bus.tx_ready_o && t < LIMIT) begin
            @(negedge clk_i);
            t++;
        end
        check("accept_timeout", (t < LIMIT), 1);
        @(posedge clk_i);
        exp_q.push_back(rx_exp);
        mosi_q.push_back(px);
        miso_q.push_back(miso);
        #1;
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || bus.busy_o) && t < LIMIT) begin
            @(negedge clk_i);
            t++;
        end
        check("idle_timeout", (t < LIMIT), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [PX-1:0] tx;
        logic [PX-1:0] miso;
        logic          loop;
        logic          b2b;
        logic [PX-1:0] rx_exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int guard;
        int n;
        int k;
        int frames_before;
        logic [PX-1:0] r;

        vecs[0] = '{tx: 24'hA5C3F0, miso: 24'h000000, loop: 1'b1, b2b: 1'b0, rx_exp: 24'hA5C3F0};
        vecs[1] = '{tx: 24'hFFFFFF, miso: 24'h0F1E2D, loop: 1'b0, b2b: 1'b0, rx_exp: 24'h0F1E2D};
        vecs[2] = '{tx: 24'h000000, miso: 24'h000000, loop: 1'b1, b2b: 1'b1, rx_exp: 24'h000000};
        vecs[3] = '{tx: 24'hFFFFFF, miso: 24'h000000, loop: 1'b1, b2b: 1'b1, rx_exp: 24'hFFFFFF};
        vecs[4] = '{tx: 24'h123456, miso: 24'h000000, loop: 1'b1, b2b: 1'b0, rx_exp: 24'h123456};

        nreset_i       = 1'b0;
        loopback       = 1'b1;
        bus.tx_px_i    = '0;
        bus.tx_valid_i = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            bus.tx_px_i    = PX'($urandom);
            bus.tx_valid_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk_i);
        check("rst_cs", bus.spi_cs_o, 1);
        check("rst_sck", bus.spi_sck_o, 0);
        check("rst_sdo", bus.spi_sdo_o, 0);
        check("rst_rx_valid", bus.rx_valid_o, 0);
        check("rst_tx_ready", bus.tx_ready_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_rx_px", bus.rx_px_o, 0);
        check("rst_state", bus.dbg_state_o, 0);
        bus.tx_valid_i = 1'b0;
        nreset_i       = 1'b1;
        @(negedge clk_i);
        check("post_rst_tx_ready", bus.tx_ready_o, 1);
        check("post_rst_cs", bus.spi_cs_o, 1);

        // Table-driven frames; the last three run back to back.
        for (int i = 0; i < 5; i++) begin
            loopback = vecs[i].loop;
            send(vecs[i].tx, vecs[i].miso, vecs[i].rx_exp);
            if (!vecs[i].b2b) wait_idle();
        end
        n = gap_log.size();
        check("b2b_gap_2", (n >= 2) ? gap_log[n-2] : -1, CS_HOLD + 1);
        check("b2b_gap_3", (n >= 2) ? gap_log[n-1] : -1, CS_HOLD + 1);
        check("rx_px_held", bus.rx_px_o, 24'h123456);

        // Random loopback frames.
        for (int i = 0; i < 3; i++) begin
            r = PX'($urandom_range(0, 32'h00FF_FFFF));
            send(r, '0, r);
            wait_idle();
        end

        // tx_valid pulsed mid-frame must be ignored.
        loopback = 1'b1;
        send(24'h3C3C3C, '0, 24'h3C3C3C);
        repeat (40) @(negedge clk_i);
        frames_before  = mon_frames;
        bus.tx_px_i    = 24'hDEAD00;
        bus.tx_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("midframe_tx_ready", bus.tx_ready_o, 0);
        end
        bus.tx_valid_i = 1'b0;
        guard = 0;
        while (!bus.rx_valid_o && guard < LIMIT) begin
            @(negedge clk_i);
            guard++;
        end
        check("midframe_rx_timeout", (guard < LIMIT), 1);
        k = 0;
        while (!bus.tx_ready_o && k < LIMIT) begin
            @(negedge clk_i);
            k++;
        end
        check("ready_after_gap", k, CS_HOLD);
        repeat (30) @(negedge clk_i);
        check("no_extra_frame", mon_frames, frames_before);
        check("idle_cs_high", bus.spi_cs_o, 1);

        // Reset in the middle of bit 10, then a clean frame.
        send(24'hC0FFEE, '0, 24'hC0FFEE);
        guard = 0;
        while (mon_rise < 10 && guard < LIMIT) begin
            @(negedge clk_i);
            guard++;
        end
        check("bit10_reached", (guard < LIMIT), 1);
        check("bit10_cs_low", bus.spi_cs_o, 0);
        #2;
        nreset_i = 1'b0;
        #1;
        check("abort_cs", bus.spi_cs_o, 1);
        check("abort_sck", bus.spi_sck_o, 0);
        check("abort_rx_valid", bus.rx_valid_o, 0);
        repeat (2) @(negedge clk_i);
        check("abort_rx_px", bus.rx_px_o, 0);
        exp_q.delete();
        mosi_q.delete();
        miso_q.delete();
        nreset_i = 1'b1;
        @(negedge clk_i);
        send(24'h000001, '0, 24'h000001);
        wait_idle();
        check("final_rx_px", bus.rx_px_o, 24'h000001);
        check("stray_sck_edges", stray_edges, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
